// File: rtl/sddr_init_seq.sv
// DDR3 power-up initialisation (RESET#/CKE/MRS/ZQCL) and periodic auto-refresh
// sequencer driving the controller-side command pins of the PHY.
module sddr_init_seq #(
    parameter int BANK_BITS      = 3,
    parameter int ADDR_BITS      = 14,
    parameter int RESET_CYCLES   = 60000,
    parameter int CKE_CYCLES     = 150000,
    parameter int TXPR_CYCLES    = 120,
    parameter int TMRD_CYCLES    = 4,
    parameter int TMOD_CYCLES    = 12,
    parameter int TZQINIT_CYCLES = 512,
    parameter int TREFI_CYCLES   = 2340,
    parameter int TRFC_CYCLES    = 48,
    parameter logic [ADDR_BITS-1:0] MR0_VAL = 'h0520,
    parameter logic [ADDR_BITS-1:0] MR1_VAL = 'h0004,
    parameter logic [ADDR_BITS-1:0] MR2_VAL = 'h0008,
    parameter logic [ADDR_BITS-1:0] MR3_VAL = 'h0000
) (
    input  logic                 in_ddr_clock_i,
    input  logic                 in_reset_i,
    output logic                 ctl_ddr_reset_n_o,
    output logic                 ctl_cke_o,
    output logic                 ctl_odt_o,
    output logic                 ctl_ras_n_o,
    output logic                 ctl_cas_n_o,
    output logic                 ctl_we_n_o,
    output logic [BANK_BITS-1:0] ctl_ba_o,
    output logic [ADDR_BITS-1:0] ctl_addr_o,
    output logic                 init_done_o,
    output logic                 ref_busy_o,
    output logic                 cmd_allow_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // RST_LOW is loaded with the full count because its count starts at the
    // reset edge, one edge before cycle 0; every other wait loads duration-1.
    localparam int INIT_MAX = max2(RESET_CYCLES, max2(CKE_CYCLES - 1,
                              max2(TXPR_CYCLES - 1, max2(TMRD_CYCLES - 1,
                              max2(TMOD_CYCLES - 1, max2(TZQINIT_CYCLES - 1,
                                   TRFC_CYCLES - 1))))));
    localparam int CW = $clog2(INIT_MAX + 1);
    localparam int RW = $clog2(TREFI_CYCLES);

    localparam logic [CW-1:0] RESET_LOAD = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] CKE_LOAD   = CW'(CKE_CYCLES - 1);
    localparam logic [CW-1:0] TXPR_LOAD  = CW'(TXPR_CYCLES - 1);
    localparam logic [CW-1:0] TMRD_LOAD  = CW'(TMRD_CYCLES - 1);
    localparam logic [CW-1:0] TMOD_LOAD  = CW'(TMOD_CYCLES - 1);
    localparam logic [CW-1:0] TZQ_LOAD   = CW'(TZQINIT_CYCLES - 1);
    localparam logic [CW-1:0] TRFC_LOAD  = CW'(TRFC_CYCLES - 1);
    localparam logic [RW-1:0] TREFI_LOAD = RW'(TREFI_CYCLES - 1);

    localparam logic [ADDR_BITS-1:0] ZQCL_ADDR = {{(ADDR_BITS-11){1'b0}}, 1'b1, 10'b0};

    typedef enum logic [3:0] {
        ST_RST_LOW, ST_CKE_LOW, ST_TXPR, ST_MRS2, ST_MRS3, ST_MRS1,
        ST_MRS0, ST_ZQCL, ST_ZQ_WAIT, ST_IDLE, ST_REFRESH
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   ref_cnt;

    always_ff @(posedge in_ddr_clock_i) begin
        if (in_reset_i) begin
            state             <= ST_RST_LOW;
            cnt               <= RESET_LOAD;
            ref_cnt           <= '0;
            ctl_ddr_reset_n_o <= 1'b0;
            ctl_cke_o         <= 1'b0;
            ctl_odt_o         <= 1'b0;
            ctl_ras_n_o       <= 1'b1;
            ctl_cas_n_o       <= 1'b1;
            ctl_we_n_o        <= 1'b1;
            ctl_ba_o          <= '0;
            ctl_addr_o        <= '0;
            init_done_o       <= 1'b0;
            ref_busy_o        <= 1'b0;
            cmd_allow_o       <= 1'b0;
        end else begin
            // Every cycle is a NOP unless a transition below issues a command.
            ctl_odt_o   <= 1'b0;
            ctl_ras_n_o <= 1'b1;
            ctl_cas_n_o <= 1'b1;
            ctl_we_n_o  <= 1'b1;
            ctl_ba_o    <= '0;
            ctl_addr_o  <= '0;
            case (state)
                ST_RST_LOW: begin
                    if (cnt == '0) begin
                        state             <= ST_CKE_LOW;
                        ctl_ddr_reset_n_o <= 1'b1;
                        cnt               <= CKE_LOAD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_CKE_LOW: begin
                    if (cnt == '0) begin
                        state     <= ST_TXPR;
                        ctl_cke_o <= 1'b1;
                        cnt       <= TXPR_LOAD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_TXPR, ST_MRS2, ST_MRS3, ST_MRS1: begin
                    if (cnt == '0) begin
                        ctl_ras_n_o <= 1'b0;
                        ctl_cas_n_o <= 1'b0;
                        ctl_we_n_o  <= 1'b0;
                        cnt         <= TMRD_LOAD;
                        case (state)
                            ST_TXPR: begin
                                state      <= ST_MRS2;
                                ctl_ba_o   <= BANK_BITS'(2);
                                ctl_addr_o <= MR2_VAL;
                            end
                            ST_MRS2: begin
                                state      <= ST_MRS3;
                                ctl_ba_o   <= BANK_BITS'(3);
                                ctl_addr_o <= MR3_VAL;
                            end
                            ST_MRS3: begin
                                state      <= ST_MRS1;
                                ctl_ba_o   <= BANK_BITS'(1);
                                ctl_addr_o <= MR1_VAL;
                            end
                            default: begin
                                state      <= ST_MRS0;
                                ctl_ba_o   <= '0;
                                ctl_addr_o <= MR0_VAL;
                                cnt        <= TMOD_LOAD;
                            end
                        endcase
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_MRS0: begin
                    if (cnt == '0) begin
                        state      <= ST_ZQCL;
                        ctl_we_n_o <= 1'b0;
                        ctl_addr_o <= ZQCL_ADDR;
                        cnt        <= TZQ_LOAD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_ZQCL, ST_ZQ_WAIT: begin
                    if (cnt == '0) begin
                        state       <= ST_IDLE;
                        init_done_o <= 1'b1;
                        cmd_allow_o <= 1'b1;
                        ref_cnt     <= TREFI_LOAD;
                    end else begin
                        state <= ST_ZQ_WAIT;
                        cnt   <= cnt - CW'(1);
                    end
                end
                ST_IDLE: begin
                    if (ref_cnt == '0) begin
                        state       <= ST_REFRESH;
                        ctl_ras_n_o <= 1'b0;
                        ctl_cas_n_o <= 1'b0;
                        ref_busy_o  <= 1'b1;
                        cmd_allow_o <= 1'b0;
                        ref_cnt     <= TREFI_LOAD;
                        cnt         <= TRFC_LOAD;
                    end else begin
                        ref_cnt <= ref_cnt - RW'(1);
                    end
                end
                ST_REFRESH: begin
                    // The REF-to-REF interval keeps counting through the busy window.
                    if (ref_cnt != '0) begin
                        ref_cnt <= ref_cnt - RW'(1);
                    end
                    if (cnt == '0) begin
                        state       <= ST_IDLE;
                        ref_busy_o  <= 1'b0;
                        cmd_allow_o <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= ST_RST_LOW;
                    cnt   <= RESET_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sddr_init_seq.sv
// Directed bench for sddr_init_seq: a driver pushes the expected per-cycle output
// word into a queue and a negedge monitor pops and compares it against the DUT.
module tb_sddr_init_seq;

    localparam int BB = 3;
    localparam int AB = 14;
    localparam int VW = 9 + BB + AB;

    localparam logic [AB-1:0] MR0 = 14'h0520;
    localparam logic [AB-1:0] MR1 = 14'h0044;
    localparam logic [AB-1:0] MR2 = 14'h0218;
    localparam logic [AB-1:0] MR3 = 14'h0003;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ddr_reset_n, cke, odt, ras_n, cas_n, we_n;
    logic [BB-1:0] ba;
    logic [AB-1:0] addr;
    logic          init_done, ref_busy, cmd_allow;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] exp_q[$];
    int            tag_q[$];
    logic [VW-1:0] rst_vec;
    logic [VW-1:0] obs;

    sddr_init_seq #(
        .BANK_BITS(BB), .ADDR_BITS(AB),
        .RESET_CYCLES(4), .CKE_CYCLES(3), .TXPR_CYCLES(2),
        .TMRD_CYCLES(4), .TMOD_CYCLES(5), .TZQINIT_CYCLES(6),
        .TREFI_CYCLES(10), .TRFC_CYCLES(3),
        .MR0_VAL(MR0), .MR1_VAL(MR1), .MR2_VAL(MR2), .MR3_VAL(MR3)
    ) dut (
        .in_ddr_clock_i(clk),
        .in_reset_i(rst),
        .ctl_ddr_reset_n_o(ddr_reset_n),
        .ctl_cke_o(cke),
        .ctl_odt_o(odt),
        .ctl_ras_n_o(ras_n),
        .ctl_cas_n_o(cas_n),
        .ctl_we_n_o(we_n),
        .ctl_ba_o(ba),
        .ctl_addr_o(addr),
        .init_done_o(init_done),
        .ref_busy_o(ref_busy),
        .cmd_allow_o(cmd_allow)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    assign obs = {ddr_reset_n, cke, odt, ras_n, cas_n, we_n, ba, addr,
                  init_done, ref_busy, cmd_allow};

    // Expected outputs in cycle k after reset release, from the hand timeline:
    // reset_n@4, CKE@7, MRS@9/13/17/21, ZQCL@26, done@32, REF@42+10n busy 3.
    function automatic logic [VW-1:0] exp_cycle(input int k);
        logic rn, ck, r, c, w, done, busy;
        logic [BB-1:0] b;
        logic [AB-1:0] a;
        rn = (k >= 4);
        ck = (k >= 7);
        r = 1'b1; c = 1'b1; w = 1'b1;
        b = '0;
        a = '0;
        case (k)
            9:  begin r = 0; c = 0; w = 0; b = 3'd2; a = MR2; end
            13: begin r = 0; c = 0; w = 0; b = 3'd3; a = MR3; end
            17: begin r = 0; c = 0; w = 0; b = 3'd1; a = MR1; end
            21: begin r = 0; c = 0; w = 0; b = 3'd0; a = MR0; end
            26: begin w = 0; a[10] = 1'b1; end
            default: ;
        endcase
        done = (k >= 32);
        busy = (k >= 42) && (((k - 42) % 10) < 3);
        if ((k >= 42) && (((k - 42) % 10) == 0)) begin
            r = 0;
            c = 0;
        end
        return {rn, ck, 1'b0, r, c, w, b, a, done, busy, done & ~busy};
    endfunction

    // driver tasks: set the input for the current cycle, then queue what the
    // DUT must show in the cycle that starts at the next edge
    task automatic drive(input logic rst_val, input logic [VW-1:0] exp, input int tag);
        rst = rst_val;
        @(posedge clk);
        #1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, rst_vec, -1);
    endtask

    task automatic run_seq(input int first, input int last);
        for (int k = first; k <= last; k++) drive(1'b0, exp_cycle(k), k);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [VW-1:0] e;
            int t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL outputs cycle=%0d got=%h required=%h (rn,cke,odt,ras,cas,we,ba,addr,done,busy,allow)",
                         t, obs, e);
            end
        end
        if (cke === 1'b0) begin
            checks++;
            if ({ras_n, cas_n, we_n} !== 3'b111) begin
                errors++;
                $display("FAIL nop_while_cke_low got=%b required=111 at %0t",
                         {ras_n, cas_n, we_n}, $time);
            end
        end
    end

    initial begin
        rst_vec = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, {BB{1'b0}}, {AB{1'b0}},
                   1'b0, 1'b0, 1'b0};
        @(posedge clk);
        #1;

        // reset held: outputs stay at reset values
        hold_reset(5);

        // full init, then REF at 42/52/62
        run_seq(0, 65);

        // reset between MR3 and MR1, then full rerun
        hold_reset(2);
        run_seq(0, 15);
        hold_reset(3);
        run_seq(0, 35);

        // reset inside a REF busy window, then full rerun to the first REF
        hold_reset(2);
        run_seq(0, 43);
        hold_reset(2);
        run_seq(0, 46);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sddr_init_seq.md
# sddr_init_seq

DDR3 power-up initialisation and periodic refresh sequencer, running in the DDR clock domain directly upstream of the Xilinx DDR PHY. It drives the PHY's controller-side command pins (`ctl_*`) and the DRAM reset and address/bank lines. On the way to operational mode it executes the JEDEC reset/CKE/MRS/ZQCL sequence. Afterwards it issues auto-refresh at a fixed interval and tells the downstream command arbiter when the command bus is free.

## Interface
- `BANK_BITS`, default 3: bank address width.
- `ADDR_BITS`, default 14: DRAM address width.
- `RESET_CYCLES`, default 60000: cycles with `ddr3_reset_n` low.
- `CKE_CYCLES`, default 150000: cycles with reset high and CKE low.
- `TXPR_CYCLES`, default 120: cycles with CKE high before the first MRS.
- `TMRD_CYCLES`, default 4: spacing from an MRS to the next MRS.
- `TMOD_CYCLES`, default 12: spacing from MR0 to ZQCL.
- `TZQINIT_CYCLES`, default 512: spacing from ZQCL to `init_done_o`.
- `TREFI_CYCLES`, default 2340: spacing from one REF to the next REF.
- `TRFC_CYCLES`, default 48: REF busy window.
- `MR0_VAL`, `MR1_VAL`, `MR2_VAL`, `MR3_VAL`, defaults 'h0520 / 'h0004 / 'h0008 / 'h0000: mode register contents, each `ADDR_BITS` wide.
- All timing parameters must be ≥ 1. Requirements: `TMRD` ≥ 1, `TRFC` < `TREFI`.
- `in_ddr_clock_i` input 1: the single clock for the block.
- `in_reset_i` input 1: reset, synchronous, active-high.
- `ctl_ddr_reset_n_o` output 1: DRAM RESET#.
- `ctl_cke_o` output 1: to PHY `ctl_cke_i`.
- `ctl_odt_o` output 1: to PHY `ctl_odt_i`; always 0 in this block.
- `ctl_ras_n_o`, `ctl_cas_n_o`, `ctl_we_n_o` output 1 each: command pins.
- `ctl_ba_o` output `BANK_BITS`: bank address.
- `ctl_addr_o` output `ADDR_BITS`: address.
- `init_done_o` output 1: initialisation complete; stays high until the next reset.
- `ref_busy_o` output 1: a REF is in progress.
- `cmd_allow_o` output 1: equals `init_done_o & !ref_busy_o`. The arbiter may drive the bus only while this is high.

## Operation
- All outputs are registered.
- Reset values:
  - `ctl_ddr_reset_n_o` = 0, `ctl_cke_o` = 0, `ctl_odt_o` = 0.
  - `ras_n`/`cas_n`/`we_n` = 1/1/1 (NOP).
  - `ba` = 0, `addr` = 0.
  - `init_done_o` = 0, `ref_busy_o` = 0, `cmd_allow_o` = 0.
- Commands. Each command lasts exactly one cycle; every non-command cycle is a NOP with `ba`/`addr` = 0.
  - MRS: `ras_n`/`cas_n`/`we_n` = 0/0/0, `ba` = register index.
  - ZQCL: 1/1/0, `addr[10]` = 1, `ba` = 0.
  - REF: 0/0/1.
- States: RST_LOW → CKE_LOW → TXPR → MRS2 → MRS3 → MRS1 → MRS0 → ZQCL → ZQ_WAIT → IDLE ⇄ REFRESH.
- RST_LOW: reset_n 0, CKE 0, held for `RESET_CYCLES`.
- CKE_LOW: reset_n 1, CKE 0, held for `CKE_CYCLES`.
- TXPR: CKE 1, NOP, held for `TXPR_CYCLES`.
- MRS2, MRS3, MRS1:
  - Issue MRS with `ba` = 2, 3, 1 and `addr` = MR2/MR3/MR1_VAL respectively.
  - The next command is issued `TMRD_CYCLES` after the current one.
- MRS0: issue MRS with `ba` = 0, `addr` = MR0_VAL. ZQCL follows `TMOD_CYCLES` later.
- ZQCL: issue the ZQCL command. `init_done_o` rises `TZQINIT_CYCLES` later.
- CKE stays 1 and reset_n stays 1 from their rise until reset.
- IDLE:
  - The interval counter starts in the cycle `init_done_o` first rises.
  - REF is issued `TREFI_CYCLES` after that, then every `TREFI_CYCLES` REF-to-REF.
  - The interval counter keeps running during REFRESH.
- REFRESH: `ref_busy_o` is high for `TRFC_CYCLES` cycles, starting with the REF cycle.
- Counters:
  - One shared down-counter for init waits plus an independent refresh-interval counter.
  - Each counter width is the `$clog2` of the largest value it must hold.
  - No wrap: counters are reloaded on each state entry or REF.
- Reset mid-operation, in any state, including mid-REF: on the next edge all outputs return to their reset values and the FSM returns to RST_LOW. The full sequence then reruns.

## Timing
- Cycle 0 is the first cycle after the edge at which `in_reset_i` is sampled low. Outputs still hold their reset values in cycle 0.
- Timeline:
  - Cycle `RESET_CYCLES`: reset_n rises.
  - `+CKE_CYCLES`: CKE rises.
  - `+TXPR_CYCLES`: MR2.
  - Then MR3, MR1, MR0 at `TMRD` spacing.
  - ZQCL at MR0 + `TMOD`.
  - `init_done_o` at ZQCL + `TZQINIT`.
- `cmd_allow_o` falls in the same cycle as the REF and rises in cycle REF + `TRFC`.
- `ctl_odt_o` is constant 0.

## Test plan
- Parameters `RESET`=4, `CKE`=3, `TXPR`=2, `TMRD`=4, `TMOD`=5, `TZQINIT`=6. Release reset:
  - reset_n rises in cycle 4, CKE in cycle 7.
  - MRS in cycles 9/13/17/21 with `ba` = 2/3/1/0 and `addr` = the MR values.
  - ZQCL in cycle 26 with `addr[10]` = 1.
  - `init_done_o` in cycle 32.
  - Every other cycle is a NOP with `ba`/`addr` = 0.
- Same parameters plus `TREFI`=10, `TRFC`=3:
  - REF in cycles 42, 52, 62.
  - `ref_busy_o` high in cycles 42–44.
  - `cmd_allow_o` low in cycles 42–44 and high otherwise from cycle 32.
- Hold `in_reset_i` high for 5 cycles: all outputs stay at their reset values throughout, with NOP on the command pins.
- Assert reset in cycle 15 (between MR3 and MR1):
  - From cycle 16, reset_n and CKE are 0, `init_done_o` is 0, and the command is NOP.
  - After release, the sequence restarts from cycle 0 timing.
- Assert reset during a REF busy window: `ref_busy_o` and `init_done_o` are 0 on the next cycle, and the next REF occurs only after a full re-initialisation.
- Throughout every test, assert that no command other than NOP appears while CKE is 0.
